// File: rtl/sysace_pkg.sv
// Shared types and constants for the SystemACE read scheduler.
// Holds the FSM encoding, LBA width default and the nsectors encoder.
package sysace_pkg;

   localparam int LBA_W_DEF       = 28;
   localparam int SECTOR_WORDS128 = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_UPDATE
   } state_t;

   // Engine takes an 8-bit count where 0 means 256 sectors.
   function automatic logic [7:0] nsec_enc(input logic [8:0] chunk);
      return (chunk == 9'd256) ? 8'd0 : chunk[7:0];
   endfunction

endpackage

// File: rtl/sysace_rd_sched_if.sv
// Bundle between the scheduler, its two requesters and the MPU read engine.
// master: scheduler side; slave: requesters, engine and downstream FIFO.
interface sysace_rd_sched_if #(
   parameter int LBA_W = 28
);
   logic [1:0]         req;
   logic [2*LBA_W-1:0] req_lba;
   logic [31:0]        req_cnt;
   logic [1:0]         ack;
   logic [1:0]         done;
   logic [LBA_W-1:0]   mpulba;
   logic [7:0]         nsectors;
   logic               sysace_start;
   logic               sysace_busy;
   logic               fifo_prog_full;
   logic               owner;
   logic               owner_valid;
   logic               busy;

   modport master (
      input  req, req_lba, req_cnt, sysace_busy, fifo_prog_full,
      output ack, done, mpulba, nsectors, sysace_start,
      output owner, owner_valid, busy
   );

   modport slave (
      output req, req_lba, req_cnt, sysace_busy, fifo_prog_full,
      input  ack, done, mpulba, nsectors, sysace_start,
      input  owner, owner_valid, busy
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: with both pending, grants the one not served last.
// i_pending/i_last/i_en in; o_gnt_valid/o_gnt_id out (combinational).
module rr_arb2 (
   input  logic [1:0] i_pending,
   input  logic       i_last,
   input  logic       i_en,
   output logic       o_gnt_valid,
   output logic       o_gnt_id
);

   always_comb begin
      o_gnt_valid = i_en && (|i_pending);
      o_gnt_id    = 1'b0;
      if (i_pending == 2'b11) begin
         o_gnt_id = ~i_last;
      end else begin
         o_gnt_id = i_pending[1];
      end
   end

endmodule

// File: rtl/sysace_rd_sched.sv
// Splits two requesters' sector-read jobs into chunks and issues them to the engine.
// CLK/RST plain; bus (master) carries req/ack/done, engine command and FIFO status.
module sysace_rd_sched
   import sysace_pkg::*;
#(
   parameter int CHUNK_SECTORS = 8,
   parameter int LBA_W         = LBA_W_DEF
) (
   input  logic CLK,
   input  logic RST,
   sysace_rd_sched_if.master bus
);

   localparam logic [15:0] CHUNK_16 = 16'(CHUNK_SECTORS);
   localparam logic [8:0]  CHUNK_9  = 9'(CHUNK_SECTORS);

   state_t           r_state;
   state_t           w_next;
   logic [LBA_W-1:0] r_lba [2];
   logic [15:0]      r_rem [2];
   logic [1:0]       r_ack;
   logic [1:0]       r_done;
   logic             r_owner;
   logic             r_last;
   logic [LBA_W-1:0] r_mpulba;
   logic [8:0]       r_chunk;

   logic [1:0]  w_pending;
   logic [1:0]  w_empty;
   logic [1:0]  w_cap;
   logic        w_ov;
   logic        w_gnt_valid;
   logic        w_gnt_id;
   logic [15:0] w_rem_sel;
   logic [8:0]  w_chunk;
   logic [15:0] w_rem_after;

   assign w_ov         = (r_state != ST_IDLE);
   assign w_pending[0] = (r_rem[0] != 16'd0);
   assign w_pending[1] = (r_rem[1] != 16'd0);

   // r_ack keeps a zero-count job busy until its done cycle.
   assign w_empty[0] = !w_pending[0] && !(w_ov && !r_owner) && !r_ack[0];
   assign w_empty[1] = !w_pending[1] && !(w_ov && r_owner) && !r_ack[1];
   assign w_cap      = bus.req & w_empty;

   assign w_rem_sel   = r_rem[w_gnt_id];
   assign w_chunk     = (w_rem_sel > CHUNK_16) ? CHUNK_9 : w_rem_sel[8:0];
   assign w_rem_after = r_rem[r_owner] - {7'd0, r_chunk};

   rr_arb2 u_arb (
      .i_pending   (w_pending),
      .i_last      (r_last),
      .i_en        (r_state == ST_IDLE && !bus.fifo_prog_full),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:    if (w_gnt_valid) w_next = ST_START;
         ST_START:   w_next = ST_WAIT_HI;
         ST_WAIT_HI: if (bus.sysace_busy) w_next = ST_WAIT_LO;
         ST_WAIT_LO: if (!bus.sysace_busy) w_next = ST_UPDATE;
         ST_UPDATE:  w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_lba[0] <= '0;
         r_lba[1] <= '0;
         r_rem[0] <= '0;
         r_rem[1] <= '0;
         r_ack    <= '0;
         r_done   <= '0;
         r_owner  <= 1'b0;
         r_last   <= 1'b1;
         r_mpulba <= '0;
         r_chunk  <= '0;
      end else begin
         r_ack  <= w_cap;
         // A job captured with cnt=0 completes right after its ack.
         r_done <= r_ack & {!w_pending[1], !w_pending[0]};
         for (int i = 0; i < 2; i++) begin
            if (w_cap[i]) begin
               r_lba[i] <= bus.req_lba[i*LBA_W +: LBA_W];
               r_rem[i] <= bus.req_cnt[i*16 +: 16];
            end
         end
         if (r_state == ST_IDLE && w_gnt_valid) begin
            r_owner  <= w_gnt_id;
            r_mpulba <= r_lba[w_gnt_id];
            r_chunk  <= w_chunk;
         end
         if (r_state == ST_UPDATE) begin
            r_lba[r_owner] <= r_lba[r_owner] + LBA_W'(r_chunk);
            r_rem[r_owner] <= w_rem_after;
            r_last         <= r_owner;
            if (w_rem_after == 16'd0) begin
               r_done[r_owner] <= 1'b1;
            end
         end
      end
   end

   assign bus.ack          = r_ack;
   assign bus.done         = r_done;
   assign bus.mpulba       = r_mpulba;
   assign bus.nsectors     = nsec_enc(r_chunk);
   assign bus.sysace_start = (r_state == ST_START);
   assign bus.owner        = r_owner;
   assign bus.owner_valid  = w_ov;
   assign bus.busy         = (|w_pending) || w_ov;

endmodule

// File: tb/tb_sysace_rd_sched.sv
// Scoreboard bench for sysace_rd_sched: three instances (CHUNK 8, 256, 1),
// directed jobs push expected commands/dones; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_sysace_rd_sched;

   typedef struct packed {
      logic [1:0]  k;
      logic        own;
      logic [27:0] lba;
      logic [7:0]  ns;
   } cmd_t;

   typedef struct packed {
      logic [1:0]  k;
      logic        own;
      logic [31:0] nst;
   } dn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sysace_rd_sched_if #(.LBA_W(28)) if_a ();
   sysace_rd_sched_if #(.LBA_W(28)) if_b ();
   sysace_rd_sched_if #(.LBA_W(28)) if_c ();

   sysace_rd_sched #(.CHUNK_SECTORS(8), .LBA_W(28)) u_a (
      .CLK (clk), .RST (rst), .bus (if_a.master));
   sysace_rd_sched #(.CHUNK_SECTORS(256), .LBA_W(28)) u_b (
      .CLK (clk), .RST (rst), .bus (if_b.master));
   sysace_rd_sched #(.CHUNK_SECTORS(1), .LBA_W(28)) u_c (
      .CLK (clk), .RST (rst), .bus (if_c.master));

   // Engine model: busy rises the cycle after start and holds e_len cycles.
   int e_len = 50;
   int e_cnt [3] = '{0, 0, 0};
   always @(posedge clk) begin
      e_cnt[0] <= if_a.sysace_start ? e_len : (e_cnt[0] > 0 ? e_cnt[0] - 1 : 0);
      e_cnt[1] <= if_b.sysace_start ? e_len : (e_cnt[1] > 0 ? e_cnt[1] - 1 : 0);
      e_cnt[2] <= if_c.sysace_start ? e_len : (e_cnt[2] > 0 ? e_cnt[2] - 1 : 0);
   end
   assign if_a.sysace_busy = (e_cnt[0] != 0);
   assign if_b.sysace_busy = (e_cnt[1] != 0);
   assign if_c.sysace_busy = (e_cnt[2] != 0);

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   int n_st   = 0;
   int t_ack0 = -1;
   int t_done0 = -1;
   int t_st   = -1;
   cmd_t q_cmd [$];
   dn_t  q_dn  [$];

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // {ack[43:42], done[41:40], mpulba[39:12], nsec[11:4], start, owner, ov, busy}
   function automatic logic [43:0] outs(input int k);
      logic [43:0] v;
      case (k)
         0: v = {if_a.ack, if_a.done, if_a.mpulba, if_a.nsectors,
                 if_a.sysace_start, if_a.owner, if_a.owner_valid, if_a.busy};
         1: v = {if_b.ack, if_b.done, if_b.mpulba, if_b.nsectors,
                 if_b.sysace_start, if_b.owner, if_b.owner_valid, if_b.busy};
         default:
            v = {if_c.ack, if_c.done, if_c.mpulba, if_c.nsectors,
                 if_c.sysace_start, if_c.owner, if_c.owner_valid, if_c.busy};
      endcase
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
      end
   endtask

   task automatic exp_cmd(input int k, input logic own,
                          input logic [27:0] lba, input logic [7:0] ns);
      q_cmd.push_back({k[1:0], own, lba, ns});
   endtask

   task automatic exp_dn(input int k, input logic own, input int nst);
      q_dn.push_back({k[1:0], own, nst[31:0]});
   endtask

   always @(negedge clk) begin : monitor
      logic [43:0] o;
      cmd_t e;
      dn_t  d;
      for (int k = 0; k < 3; k++) begin
         o = outs(k);
         if (o[3]) begin
            n_st++;
            if (k == 0) t_st = cyc_n;
            if (q_cmd.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_start: inst %0d lba 0x%0h, required no command",
                        k, o[39:12]);
            end else begin
               e = q_cmd.pop_front();
               chk("cmd", {k[1:0], o[2], o[39:12], o[11:4]}, e);
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (o[40+i]) begin
               if (k == 0 && i == 0) t_done0 = cyc_n;
               if (q_dn.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: inst %0d id %0d, required none", k, i);
               end else begin
                  d = q_dn.pop_front();
                  chk("done_id", {k[1:0], i[0]}, {d.k, d.own});
                  chk("done_after_starts", n_st, d.nst);
               end
            end
         end
         if (k == 0 && o[42]) t_ack0 = cyc_n;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input int i, input logic v);
      case (k)
         0: if_a.req[i] = v;
         1: if_b.req[i] = v;
         default: if_c.req[i] = v;
      endcase
   endtask

   task automatic set_job(input int k, input int i, input logic [27:0] lba,
                          input logic [15:0] cnt);
      case (k)
         0: begin
            if_a.req_lba[i*28 +: 28] = lba;
            if_a.req_cnt[i*16 +: 16] = cnt;
         end
         1: begin
            if_b.req_lba[i*28 +: 28] = lba;
            if_b.req_cnt[i*16 +: 16] = cnt;
         end
         default: begin
            if_c.req_lba[i*28 +: 28] = lba;
            if_c.req_cnt[i*16 +: 16] = cnt;
         end
      endcase
      set_req(k, i, 1'b1);
   endtask

   task automatic do_req(input int k, input int i, input logic [27:0] lba,
                         input logic [15:0] cnt);
      int n;
      logic [43:0] o;
      n = 0;
      set_job(k, i, lba, cnt);
      do begin
         @(negedge clk);
         o = outs(k);
         n++;
      end while (!o[42+i] && n < 50);
      chk("ack_seen", o[42+i], 1'b1);
      tick(1);
      set_req(k, i, 1'b0);
   endtask

   task automatic wait_idle(input int k);
      int n;
      logic [43:0] o;
      n = 0;
      do begin
         @(negedge clk);
         o = outs(k);
         n++;
      end while ((o[0] || o[1]) && n < 3000);
      chk("idle_reached", {o[1], o[0]}, 2'b00);
      tick(3);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not complete, required completion");
      $fatal(1);
   end

   initial begin
      int b;
      int n;
      int tf;
      logic [43:0] o;
      if_a.req = '0; if_a.req_lba = '0; if_a.req_cnt = '0; if_a.fifo_prog_full = 1'b0;
      if_b.req = '0; if_b.req_lba = '0; if_b.req_cnt = '0; if_b.fifo_prog_full = 1'b0;
      if_c.req = '0; if_c.req_lba = '0; if_c.req_cnt = '0; if_c.fifo_prog_full = 1'b0;

      // Reset state
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_state_a", outs(0), 44'd0);
      chk("reset_state_b", outs(1), 44'd0);
      chk("reset_state_c", outs(2), 44'd0);
      tick(1);

      // Contention: both requesters in the same cycle, fresh pointer
      e_len = 5;
      b = n_st;
      exp_cmd(0, 1'b0, 28'h0, 8'd8);
      exp_cmd(0, 1'b1, 28'h1000, 8'd8);
      exp_cmd(0, 1'b0, 28'h8, 8'd8);
      exp_cmd(0, 1'b1, 28'h1008, 8'd8);
      exp_dn(0, 1'b0, b + 3);
      exp_dn(0, 1'b1, b + 4);
      set_job(0, 0, 28'h0, 16'd16);
      set_job(0, 1, 28'h1000, 16'd16);
      n = 0;
      do begin
         @(negedge clk);
         o = outs(0);
         n++;
      end while (o[43:42] != 2'b11 && n < 50);
      chk("ack_both_same_cycle", o[43:42], 2'b11);
      tick(1);
      set_req(0, 0, 1'b0);
      set_req(0, 1, 1'b0);
      wait_idle(0);

      // Single job split into 8/8/4
      e_len = 50;
      b = n_st;
      exp_cmd(0, 1'b0, 28'h100, 8'd8);
      exp_cmd(0, 1'b0, 28'h108, 8'd8);
      exp_cmd(0, 1'b0, 28'h110, 8'd4);
      exp_dn(0, 1'b0, b + 3);
      do_req(0, 0, 28'h100, 16'd20);
      wait_idle(0);

      // Backpressure from two cycles after ack for 100 cycles
      b = n_st;
      exp_cmd(0, 1'b0, 28'h2000, 8'd8);
      exp_cmd(0, 1'b0, 28'h2008, 8'd8);
      exp_dn(0, 1'b0, b + 2);
      do_req(0, 0, 28'h2000, 16'd16);
      tick(1);
      if_a.fifo_prog_full = 1'b1;
      chk("arb_latency", t_st - t_ack0, 1);
      chk("first_chunk_started", n_st - b, 1);
      tick(100);
      chk("no_start_under_pf", n_st - b, 1);
      if_a.fifo_prog_full = 1'b0;
      tf = cyc_n;
      n = 0;
      while (n_st - b < 2 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("start_after_pf", t_st - tf, 1);
      wait_idle(0);

      // LBA wrap at 2^28
      e_len = 3;
      b = n_st;
      exp_cmd(0, 1'b0, 28'hFFFFFFC, 8'd8);
      exp_cmd(0, 1'b0, 28'h0000004, 8'd4);
      exp_dn(0, 1'b0, b + 2);
      do_req(0, 0, 28'hFFFFFFC, 16'd12);
      wait_idle(0);

      // Zero count: ack then done, no command
      b = n_st;
      exp_dn(0, 1'b0, b);
      do_req(0, 0, 28'h7, 16'd0);
      wait_idle(0);
      chk("zero_done_latency", t_done0 - t_ack0, 1);

      // Re-request held through done cycle
      b = n_st;
      exp_cmd(0, 1'b0, 28'h300, 8'd4);
      exp_cmd(0, 1'b0, 28'h300, 8'd4);
      exp_dn(0, 1'b0, b + 1);
      exp_dn(0, 1'b0, b + 2);
      set_job(0, 0, 28'h300, 16'd4);
      n = 0;
      do begin
         @(negedge clk);
         o = outs(0);
         n++;
      end while (!o[42] && n < 50);
      chk("first_ack", o[42], 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         o = outs(0);
         n++;
      end while (!o[40] && n < 500);
      chk("first_done", o[40], 1'b1);
      @(negedge clk);
      o = outs(0);
      chk("reack_next_cycle", o[42], 1'b1);
      tick(1);
      set_req(0, 0, 1'b0);
      wait_idle(0);

      // Reset while the engine is busy (WAIT_LO)
      e_len = 20;
      b = n_st;
      exp_cmd(0, 1'b0, 28'h500, 8'd8);
      do_req(0, 0, 28'h500, 16'd8);
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_mid_chunk_outputs", outs(0), 44'd0);
      chk("reset_mid_chunk_started", n_st - b, 1);
      tick(40);
      @(negedge clk);
      chk("post_reset_quiet", outs(0), 44'd0);

      // CHUNK=256: first command encodes 256 as 0
      e_len = 5;
      b = n_st;
      exp_cmd(1, 1'b0, 28'h40, 8'd0);
      exp_cmd(1, 1'b0, 28'h140, 8'd44);
      exp_dn(1, 1'b0, b + 2);
      do_req(1, 0, 28'h40, 16'd300);
      wait_idle(1);

      // CHUNK=1: wrap from last LBA to 0
      b = n_st;
      exp_cmd(2, 1'b0, 28'hFFFFFFF, 8'd1);
      exp_cmd(2, 1'b0, 28'h0, 8'd1);
      exp_dn(2, 1'b0, b + 2);
      do_req(2, 0, 28'hFFFFFFF, 16'd2);
      wait_idle(2);

      chk("cmd_queue_empty", q_cmd.size(), 0);
      chk("done_queue_empty", q_dn.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sysace_rd_sched.md
Name: sysace_rd_sched

Overview:
Schedules SystemACE sector reads for two independent requesters, for example a bitstream loader and a data loader.
- Each requester posts one job: start LBA plus sector count.
- The block splits each job into chunks of at most CHUNK_SECTORS and drives the single SystemACE MPU read engine through mpulba/nsectors/start/busy.
- Requesters are served round-robin at chunk granularity. New chunks are held off while the downstream 128-bit FIFO is nearly full.
- owner/owner_valid let the downstream demux steer packed data to the correct consumer.

Parameters:
CHUNK_SECTORS, 8, max sectors per engine command (legal range 1..256).
LBA_W, 28, LBA width; must match the engine's mpulba.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
req  in  2  per-requester job request, level; held until ack
req_lba  in  2*LBA_W  start LBA per requester; requester i uses bits [i*LBA_W +: LBA_W]
req_cnt  in  32  sector count per requester; requester i uses bits [i*16 +: 16]
ack  out  2  one-cycle pulse: job captured
done  out  2  one-cycle pulse: job's last chunk completed
mpulba  out  LBA_W  LBA of the current chunk
nsectors  out  8  chunk length; 0 encodes 256
sysace_start  out  1  one-cycle command pulse to the engine
sysace_busy  in  1  engine busy
fifo_prog_full  in  1  downstream FIFO cannot accept another full chunk
owner  out  1  requester owning the current or last chunk
owner_valid  out  1  a chunk is in flight
busy  out  1  any job pending or any chunk in flight

Behaviour:
- Reset: all outputs 0; both slots empty; round-robin pointer favours requester 0; FSM in IDLE. Reset mid-chunk discards all jobs; the engine is not aborted, and completion of its in-flight command is ignored.
- Slot capture:
  - A slot is empty when its remaining count is 0 and it is not owner of an in-flight chunk.
  - If req[i]=1 and slot i is empty: latch lba and cnt, pulse ack[i] in the same registered cycle.
  - Requester drops req the cycle after ack.
  - cnt=0: ack, then done[i] the following cycle; no engine command is issued.
- A slot is busy from ack to its done cycle. A req seen in the done cycle is accepted the next cycle.
- FSM states: IDLE, START, WAIT_HI, WAIT_LO, UPDATE.
- IDLE: if any slot has remaining>0 and fifo_prog_full=0, pick a slot round-robin.
  - With both slots pending, choose the slot not served last.
  - Set owner, mpulba=slot lba, chunk=min(remaining, CHUNK_SECTORS), nsectors=chunk[7:0]. A chunk of 256 encodes as 0.
  - Go to START. Arbitration latency from ack: 1 cycle minimum.
- START: sysace_start=1 for exactly this one cycle; owner_valid=1; go to WAIT_HI.
- WAIT_HI: wait for sysace_busy=1, then go to WAIT_LO. A busy level still high from a previous command cannot occur here, because the FSM only leaves WAIT_LO on busy=0.
- WAIT_LO: wait for sysace_busy=0, then go to UPDATE.
- UPDATE:
  - slot lba += chunk, modulo 2^LBA_W (wraps).
  - slot remaining -= chunk.
  - If remaining becomes 0, pulse done[owner].
  - Update the round-robin pointer; owner_valid=0; go to IDLE.
- mpulba, nsectors and owner stay stable from IDLE exit through UPDATE.
- fifo_prog_full gates only new chunk issue; a chunk in flight always completes. The downstream threshold must guarantee space for CHUNK_SECTORS*32 words of 128 bits.
- busy = any slot remaining>0 or FSM != IDLE.

Decomposition:
- Shared package sysace_pkg holds:
  - FSM state encoding.
  - SECTOR_WORDS128=32.
  - LBA_W default.
  - Function nsec_enc(chunk): returns 8 bits, with 256 mapped to 0.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: pending[1:0], last, en.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- Single job: req0, lba=0x100, cnt=20, CHUNK=8, engine busy 1 cycle after start for 50 cycles.
  - Expect commands (0x100,8), (0x108,8), (0x110,4), each with owner=0.
  - Expect one done[0] pulse after the third UPDATE.
- Contention: req0 (lba 0, cnt 16) and req1 (lba 0x1000, cnt 16) in the same cycle.
  - Expect command order 0:0, 1:0x1000, 0:8, 1:0x1008.
  - Expect done[0] before done[1].
- Backpressure: fifo_prog_full=1 from cycle 2 after ack for 100 cycles.
  - No sysace_start during that window.
  - First start occurs 1 cycle after fifo_prog_full deasserts.
  - A chunk already in flight when fifo_prog_full rises completes normally.
- Boundaries:
  - CHUNK=256, cnt=256 → nsectors=0 on one command.
  - lba=0xFFFFFFF, cnt=2, CHUNK=1 → second command at mpulba=0.
  - cnt=0 → ack then done, no start pulse.
- Reset mid-chunk: assert RST in WAIT_LO.
  - Next cycle all outputs are 0 and busy=0.
  - Engine busy falling later produces no done and no start.
- Re-request timing: hold req0 through its done cycle.
  - Expect second ack exactly 1 cycle after done[0].
